// File: rtl/aqed_pkg.sv
// Shared types and constants for the AQED response-side checker.
package aqed_pkg;

    localparam int AQED_DATA_W   = 16;
    localparam int AQED_SEQ_W    = 17;
    localparam int AQED_RB_SLACK = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ORIG = 2'd1,
        WAIT_DUP  = 2'd2,
        DONE      = 2'd3
    } resp_state_t;

endpackage

// File: rtl/aqed_resp_checker_if.sv
// Issuer tag pulses plus the accelerator output stream, as seen by the response checker.
interface aqed_resp_checker_if
    import aqed_pkg::*;
#(
    parameter int DATA_W = AQED_DATA_W,
    parameter int SEQ_W  = AQED_SEQ_W
);

    logic              orig_issued;
    logic [SEQ_W-1:0]  orig_seq;
    logic              dup_issued;
    logic [SEQ_W-1:0]  dup_seq;
    logic [DATA_W-1:0] acc_out;
    logic              acc_out_v;

    modport master (
        output orig_issued, orig_seq, dup_issued, dup_seq, acc_out, acc_out_v
    );

    modport slave (
        input orig_issued, orig_seq, dup_issued, dup_seq, acc_out, acc_out_v
    );

endinterface

// File: rtl/aqed_seq_match.sv
// One tagged input (original or duplicate): holds its ordinal, detects its output
// word in the stream, captures it, and flags a repeated tag pulse.
module aqed_seq_match
    import aqed_pkg::*;
#(
    parameter int DATA_W = AQED_DATA_W,
    parameter int SEQ_W  = AQED_SEQ_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              issued_i,
    input  logic [SEQ_W-1:0]  seq_i,
    input  logic [SEQ_W-1:0]  out_cnt_i,
    input  logic [DATA_W-1:0] acc_out_i,
    input  logic              acc_out_v_i,
    input  logic              capture_en_i,
    output logic              tag_v_o,
    output logic [SEQ_W-1:0]  seq_o,
    output logic              match_o,
    output logic              double_tag_o,
    output logic [DATA_W-1:0] val_o
);

    logic              tag_v_q;
    logic [SEQ_W-1:0]  seq_q;
    logic [DATA_W-1:0] val_q;
    logic              new_tag;

    assign new_tag      = clk_en && issued_i && !tag_v_q;
    assign double_tag_o = clk_en && issued_i && tag_v_q;

    // A tag arriving this cycle is already usable, so a same-cycle output can match it.
    assign tag_v_o = tag_v_q || new_tag;
    assign seq_o   = tag_v_q ? seq_q : seq_i;
    assign match_o = clk_en && acc_out_v_i && tag_v_o && (out_cnt_i == seq_o);
    assign val_o   = val_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v_q <= 1'b0;
            seq_q   <= '0;
            val_q   <= '0;
        end else begin
            if (new_tag) begin
                tag_v_q <= 1'b1;
                seq_q   <= seq_i;
            end
            if (match_o && capture_en_i) begin
                val_q <= acc_out_i;
            end
        end
    end

endmodule

// File: rtl/aqed_resp_checker.sv
// AQED response-side checker: pairs the original/duplicate outputs and compares them.
// Optional AQED_RB_TIMEOUT_EN adds an internal response-bound timeout (rb_fail).
module aqed_resp_checker
    import aqed_pkg::*;
#(
    parameter int DATA_W = AQED_DATA_W,
    parameter int SEQ_W  = AQED_SEQ_W,
    parameter int TO_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    aqed_resp_checker_if.slave bus,
    input  logic [15:0]       depth,
    output logic              orig_done,
    output logic              qed_done,
    output logic              qed_check,
    output logic [DATA_W-1:0] orig_val,
    output logic [DATA_W-1:0] dup_val,
    output logic              proto_err
`ifdef AQED_RB_TIMEOUT_EN
    ,
    output logic              rb_fail
`endif
);

    resp_state_t      state_q, state_d;
    logic [SEQ_W-1:0] out_cnt_q, out_cnt_d;
    logic             orig_done_q, orig_done_d;
    logic             qed_done_q, qed_done_d;
    logic             qed_check_q, qed_check_d;
    logic             proto_err_q, proto_err_d;

    logic             o_tag_v, o_match, o_double, o_cap_en, o_cap;
    logic             d_tag_v, d_match, d_double, d_cap_en, d_cap;
    logic [SEQ_W-1:0] o_seq, d_seq;
    logic             ord_err;

    // Duplicate must follow the original in input order; anything else is a tagging fault.
    assign ord_err  = clk_en && (state_q != DONE) && o_tag_v && d_tag_v && (d_seq <= o_seq);
    assign o_cap_en = ((state_q == IDLE) || (state_q == WAIT_ORIG)) && !ord_err;
    assign d_cap_en = (state_q == WAIT_DUP) && !ord_err;
    assign o_cap    = o_match && o_cap_en;
    assign d_cap    = d_match && d_cap_en;

    aqed_seq_match #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_orig_match (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .issued_i     (bus.orig_issued),
        .seq_i        (bus.orig_seq),
        .out_cnt_i    (out_cnt_q),
        .acc_out_i    (bus.acc_out),
        .acc_out_v_i  (bus.acc_out_v),
        .capture_en_i (o_cap_en),
        .tag_v_o      (o_tag_v),
        .seq_o        (o_seq),
        .match_o      (o_match),
        .double_tag_o (o_double),
        .val_o        (orig_val)
    );

    aqed_seq_match #(.DATA_W(DATA_W), .SEQ_W(SEQ_W)) u_dup_match (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .issued_i     (bus.dup_issued),
        .seq_i        (bus.dup_seq),
        .out_cnt_i    (out_cnt_q),
        .acc_out_i    (bus.acc_out),
        .acc_out_v_i  (bus.acc_out_v),
        .capture_en_i (d_cap_en),
        .tag_v_o      (d_tag_v),
        .seq_o        (d_seq),
        .match_o      (d_match),
        .double_tag_o (d_double),
        .val_o        (dup_val)
    );

    always_comb begin
        state_d     = state_q;
        out_cnt_d   = out_cnt_q;
        orig_done_d = orig_done_q;
        qed_done_d  = qed_done_q;
        qed_check_d = qed_check_q;
        proto_err_d = proto_err_q || o_double || d_double || ord_err;

        if (clk_en && bus.acc_out_v && (out_cnt_q != '1)) begin
            out_cnt_d = out_cnt_q + SEQ_W'(1);
        end

        if (clk_en) begin
            unique case (state_q)
                IDLE, WAIT_ORIG: begin
                    if (ord_err) begin
                        state_d = DONE;
                    end else if (o_cap) begin
                        state_d     = WAIT_DUP;
                        orig_done_d = 1'b1;
                    end else if (o_tag_v) begin
                        state_d = WAIT_ORIG;
                    end
                end
                WAIT_DUP: begin
                    if (ord_err) begin
                        state_d = DONE;
                    end else if (d_cap) begin
                        state_d     = DONE;
                        qed_done_d  = 1'b1;
                        qed_check_d = (orig_val == bus.acc_out);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_cnt_q   <= '0;
            orig_done_q <= 1'b0;
            qed_done_q  <= 1'b0;
            qed_check_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_cnt_q   <= out_cnt_d;
            orig_done_q <= orig_done_d;
            qed_done_q  <= qed_done_d;
            qed_check_q <= qed_check_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign orig_done = orig_done_q;
    assign qed_done  = qed_done_q;
    assign qed_check = qed_check_q;
    assign proto_err = proto_err_q;

`ifdef AQED_RB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_limit;
    logic            rb_fail_q, rb_fail_d;

    assign to_limit = (TO_W'(depth) << 2) + TO_W'(AQED_RB_SLACK);

    // Compare against the next count so rb_fail rises on the edge the bound is exceeded.
    always_comb begin
        to_cnt_d  = to_cnt_q;
        rb_fail_d = rb_fail_q;
        if (clk_en) begin
            if (bus.orig_issued) begin
                to_cnt_d = '0;
            end else if ((state_q == WAIT_ORIG) && (to_cnt_q != '1)) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
            if ((state_q == WAIT_ORIG) && !o_cap && (to_cnt_d > to_limit)) begin
                rb_fail_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            rb_fail_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            rb_fail_q <= rb_fail_d;
        end
    end

    assign rb_fail = rb_fail_q;
`else
    logic depth_unused;
    assign depth_unused = ^depth;
`endif

endmodule

// File: tb/tb_aqed_resp_checker.sv
// Scoreboard bench for aqed_resp_checker; define AQED_RB_TIMEOUT_EN to also cover rb_fail.
module tb_aqed_resp_checker;
    import aqed_pkg::*;

    typedef struct {
        int          kind;   // 0 = original capture, 1 = duplicate capture
        int          cyc;
        logic [15:0] val;
        logic        chk;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic [15:0] depth;
    logic        orig_done, qed_done, qed_check, proto_err;
    logic [15:0] orig_val, dup_val;
`ifdef AQED_RB_TIMEOUT_EN
    logic        rb_fail;
`endif

    aqed_resp_checker_if bus ();

    aqed_resp_checker dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .bus       (bus),
        .depth     (depth),
        .orig_done (orig_done),
        .qed_done  (qed_done),
        .qed_check (qed_check),
        .orig_val  (orig_val),
        .dup_val   (dup_val),
        .proto_err (proto_err)
`ifdef AQED_RB_TIMEOUT_EN
        ,
        .rb_fail   (rb_fail)
`endif
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    bit   mon_en = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_od = 0, prev_qd = 0;

    // Reference model state
    logic [16:0] m_cnt, m_o_seq, m_d_seq;
    logic        m_o_v, m_d_v, m_perr;
    logic [15:0] m_orig_val;
    int          m_phase;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic model_clear();
        m_cnt = '0; m_o_seq = '0; m_d_seq = '0;
        m_o_v = 0; m_d_v = 0; m_perr = 0; m_orig_val = '0; m_phase = 0;
    endtask

    // One clock of stimulus; the model predicts captures and pushes them to the scoreboard.
    task automatic drive_cycle(input logic en, input logic v, input logic [15:0] data,
                               input logic oi, input logic [16:0] os,
                               input logic di, input logic [16:0] ds);
        exp_t e;
        @(negedge clk);
        clk_en = en; bus.acc_out_v = v; bus.acc_out = data;
        bus.orig_issued = oi; bus.orig_seq = os;
        bus.dup_issued = di; bus.dup_seq = ds;
        if (en) begin
            if (oi) begin
                if (m_o_v) m_perr = 1; else begin m_o_v = 1; m_o_seq = os; end
            end
            if (di) begin
                if (m_d_v) m_perr = 1; else begin m_d_v = 1; m_d_seq = ds; end
            end
            if (m_phase < 2 && m_o_v && m_d_v && m_d_seq <= m_o_seq) begin
                m_perr = 1;
                m_phase = 2;
            end else if (v) begin
                if (m_phase == 0 && m_o_v && m_cnt == m_o_seq) begin
                    e.kind = 0; e.cyc = edge_cnt + 1; e.val = data; e.chk = 0;
                    sb.push_back(e);
                    m_orig_val = data;
                    m_phase = 1;
                end else if (m_phase == 1 && m_d_v && m_cnt == m_d_seq) begin
                    e.kind = 1; e.cyc = edge_cnt + 1; e.val = data; e.chk = (data == m_orig_val);
                    sb.push_back(e);
                    m_phase = 2;
                end
            end
            if (v && m_cnt != 17'h1ffff) m_cnt = m_cnt + 17'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        sb.delete();
        reset = 1; clk_en = 0;
        bus.orig_issued = 0; bus.dup_issued = 0; bus.acc_out_v = 0;
        bus.orig_seq = '0; bus.dup_seq = '0; bus.acc_out = '0;
        model_clear();
        @(negedge clk);
        check_val("rst_orig_done", orig_done, 0);
        check_val("rst_qed_done", qed_done, 0);
        check_val("rst_qed_check", qed_check, 0);
        check_val("rst_orig_val", orig_val, 0);
        check_val("rst_dup_val", dup_val, 0);
        check_val("rst_proto_err", proto_err, 0);
`ifdef AQED_RB_TIMEOUT_EN
        check_val("rst_rb_fail", rb_fail, 0);
`endif
        reset = 0;
        mon_en = 1;
    endtask

    // Monitor: pop the scoreboard whenever a done flag rises.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (orig_done && !prev_od) begin
                    if (sb.size() == 0) check_val("orig_unexpected", orig_done, 0);
                    else begin
                        mon_e = sb.pop_front();
                        check_val("orig_kind", 0, mon_e.kind);
                        check_val("orig_cycle", edge_cnt, mon_e.cyc);
                        check_val("orig_val", orig_val, mon_e.val);
                        $display("orig capture edge=%0d val=%0d", edge_cnt, orig_val);
                    end
                end
                if (qed_done && !prev_qd) begin
                    if (sb.size() == 0) check_val("qed_unexpected", qed_done, 0);
                    else begin
                        mon_e = sb.pop_front();
                        check_val("dup_kind", 1, mon_e.kind);
                        check_val("dup_cycle", edge_cnt, mon_e.cyc);
                        check_val("dup_val", dup_val, mon_e.val);
                        check_val("qed_check", qed_check, mon_e.chk);
                        $display("dup capture edge=%0d val=%0d check=%0d", edge_cnt, dup_val, qed_check);
                    end
                end
                check_val("proto_err", proto_err, m_perr);
            end
            prev_od = orig_done;
            prev_qd = qed_done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        depth = 16'd4;
        reset = 1; clk_en = 0;
        bus.orig_issued = 0; bus.dup_issued = 0; bus.acc_out_v = 0;
        bus.orig_seq = '0; bus.dup_seq = '0; bus.acc_out = '0;
        model_clear();

        // Matching pair: original at 2, duplicate at 5 forced to 20
        for (int t = 0; t < 2; t++) begin
            do_reset();
            drive_cycle(1, 0, 0, 1, 17'd2, 1, 17'd5);
            for (int n = 0; n < 8; n++)
                drive_cycle(1, 1, (n == 5) ? 16'(20 + t) : 16'(10 * n), 0, 0, 0, 0);
        end

        // Tag pulses arrive in the same cycle as their matching outputs
        do_reset();
        for (int n = 0; n < 3; n++) drive_cycle(1, 1, 16'(n), 0, 0, 0, 0);
        drive_cycle(1, 1, 16'd33, 1, 17'd3, 0, 0);
        drive_cycle(1, 1, 16'd44, 0, 0, 0, 0);
        drive_cycle(1, 1, 16'd33, 0, 0, 1, 17'd5);
        drive_cycle(1, 1, 16'd66, 0, 0, 0, 0);

        // Duplicate ordinal before original: protocol error, nothing captured
        do_reset();
        drive_cycle(1, 0, 0, 1, 17'd4, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 1, 17'd1);
        for (int n = 0; n < 7; n++) drive_cycle(1, 1, 16'(100 + n), 0, 0, 0, 0);
        @(negedge clk);
        check_val("err_qed_done", qed_done, 0);
        check_val("err_qed_check", qed_check, 0);
        check_val("err_orig_done", orig_done, 0);

        // Second original pulse flags an error and its ordinal is ignored
        do_reset();
        drive_cycle(1, 0, 0, 1, 17'd2, 0, 0);
        drive_cycle(1, 0, 0, 1, 17'd1, 0, 0);
        for (int n = 0; n < 4; n++) drive_cycle(1, 1, 16'(200 + n), 0, 0, 0, 0);

        // Outputs with clk_en low around the match points are ignored
        do_reset();
        drive_cycle(1, 0, 0, 1, 17'd3, 1, 17'd6);
        for (int n = 0; n < 8; n++) begin
            if (n == 3 || n == 6) begin
                drive_cycle(0, 1, 16'hdead, 0, 0, 0, 0);
                drive_cycle(0, 1, 16'hbeef, 0, 0, 0, 0);
            end
            drive_cycle(1, 1, 16'(10 * n), 0, 0, 0, 0);
            drive_cycle(0, 1, 16'd99, 0, 0, 0, 0);
        end

        // Reset after the original capture clears everything
        do_reset();
        drive_cycle(1, 1, 16'd5, 0, 0, 0, 0);
        drive_cycle(1, 1, 16'd7, 1, 17'd1, 1, 17'd9);
        drive_cycle(1, 1, 16'd8, 0, 0, 0, 0);
        @(negedge clk);
        check_val("mid_orig_done", orig_done, 1);
        do_reset();
        drive_cycle(1, 1, 16'd77, 1, 17'd0, 0, 0);

`ifdef AQED_RB_TIMEOUT_EN
        // Response-bound timeout: depth 2 gives a limit of 16
        do_reset();
        depth = 16'd2;
        drive_cycle(1, 1, 16'd1, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 1, 17'd50, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            drive_cycle(1, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            check_val($sformatf("rb_fail_k%0d", k), rb_fail, (k >= 17) ? 1 : 0);
        end
        do_reset();
        drive_cycle(1, 1, 16'd55, 1, 17'd0, 0, 0);
        @(negedge clk);
        check_val("rb_after_rst", rb_fail, 0);
`endif

        do_reset();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aqed_resp_checker.md
Name: aqed_resp_checker

Overview:
- Response-side end of the AQED harness for the line-buffer memory core.
- Consumes the core's output stream and matches outputs to the original and duplicate inputs tagged by the input-side issuer.
- Captures the two corresponding output words and compares them. Reports qed_done/qed_check and orig_done to the formal top for the functional-consistency and response-bound properties.

Parameters:
- DATA_W, 16, width of the accelerator output data word.
- SEQ_W, 17, width of sequence counters (input/output ordinal).
- TO_W, 20, width of the response-bound timeout counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- clk_en  input  1  global enable; all state except done-stickies advances only when high.
- orig_issued  input  1  one-cycle pulse: issuer sent the original input.
- orig_seq  input  SEQ_W  input ordinal of the original; valid with orig_issued.
- dup_issued  input  1  one-cycle pulse: issuer sent the duplicate input.
- dup_seq  input  SEQ_W  input ordinal of the duplicate; valid with dup_issued.
- acc_out  input  DATA_W  core output data.
- acc_out_v  input  1  core output valid.
- depth  input  16  configured line-buffer depth; static after reset.
- orig_done  output  1  sticky: output for the original captured.
- qed_done  output  1  sticky: both outputs captured.
- qed_check  output  1  orig_val == dup_val; meaningful when qed_done.
- orig_val  output  DATA_W  captured original output.
- dup_val  output  DATA_W  captured duplicate output.
- proto_err  output  1  sticky: illegal tagging seen.

Behaviour:
- Reset: all outputs 0, out_cnt 0, FSM IDLE, seq registers 0, tag-valid flags 0.
- out_cnt increments by 1 on each clk_en && acc_out_v and saturates at all-ones. Output ordinal n corresponds to input ordinal n; the core is in-order.
- Tag capture: on orig_issued, latch orig_seq and set o_tag_v; dup_issued is handled the same way independently. Tagging is accepted in any FSM state before capture. A second pulse of the same kind sets proto_err and is ignored.
- If dup_seq <= orig_seq once both tags are valid: set proto_err; the FSM goes to DONE with qed_check = 0.
- A match fires when clk_en && acc_out_v && tag_v && out_cnt == seq. The match uses the pre-increment out_cnt, so the output word is taken in the same cycle.
- FSM states: IDLE, WAIT_ORIG, WAIT_DUP, DONE.
  - IDLE -> WAIT_ORIG on o_tag_v.
  - WAIT_ORIG -> WAIT_DUP on original match: latch orig_val, set orig_done.
  - WAIT_DUP -> DONE on duplicate match: latch dup_val, set qed_done next cycle.
  - DONE is absorbing until reset.
- qed_check is registered as (orig_val == dup_val) and is asserted in the same cycle qed_done rises.
- Simultaneous events:
  - Tag pulse in the same cycle as a matching output: the match uses the incoming seq, so it is captured in that cycle.
  - orig_issued and dup_issued together: both are latched.
- Output arriving with acc_out_v while clk_en = 0: ignored.
- out_cnt saturation while still waiting: no match is possible; this is left to the timeout (optional feature).
- Reset mid-operation: everything returns to reset values on the next edge.

Optional Feature:
- Macro: AQED_RB_TIMEOUT_EN.
- When defined:
  - Adds output rb_fail (1, sticky, reset 0) and counter to_cnt.
  - to_cnt clears on orig_issued and increments each clk_en cycle while in WAIT_ORIG.
  - rb_fail sets when to_cnt > (depth << 2) + 8 without an original match. The comparison is TO_W-wide and zero-extended; to_cnt saturates.
- When undefined: no rb_fail port and no counter. Response bound is checked only externally via orig_done.

Decomposition:
- Shared package aqed_pkg:
  - resp_state_t enum {IDLE, WAIT_ORIG, WAIT_DUP, DONE}.
  - localparams AQED_DATA_W = 16, AQED_SEQ_W = 17.
  - Timeout slack constant AQED_RB_SLACK = 8.
- Sub-module aqed_seq_match, instantiated twice (original/duplicate):
  - holds tag_v, seq, captured value and second-pulse detection;
  - exposes match and double_tag.

Test Plan:
- depth = 4, orig_seq = 2, dup_seq = 5, outputs 0..7 with values 10·n, duplicate word forced to 20 -> orig_val = 20, dup_val = 20, qed_check = 1, qed_done rises the cycle after output 5.
- Same as above but the duplicate output is 21 -> qed_done = 1, qed_check = 0.
- orig_issued with orig_seq = 3 in the same cycle as the 4th valid output (out_cnt = 3) -> captured that cycle, orig_done = 1 next cycle.
- dup_seq = 1, orig_seq = 4 -> proto_err = 1, DONE, qed_check = 0; a second orig_issued pulse also sets proto_err.
- acc_out_v toggled with clk_en = 0 around the match point -> no capture until the next enabled valid with matching out_cnt.
- AQED_RB_TIMEOUT_EN, depth = 2: no outputs after orig_issued -> rb_fail rises at cycle 17; reset asserted mid-wait -> rb_fail, orig_done, out_cnt return to 0.
